// File: rtl/mdu_e_pkg.sv
// mdu_e_pkg: shared definitions for the EX-stage multiply/divide unit.
//   - md_* opcode constants carried on MDop (4 bits)
//   - is_launch(): MDop codes that start a multi-cycle operation
//   - is_div():    launch codes that use the divide latency
// Optional feature macro: MDU_MADD_EN (adds madd/maddu as launch ops).
package mdu_e_pkg;

    localparam logic [3:0] md_none  = 4'd0;
    localparam logic [3:0] md_mult  = 4'd1;
    localparam logic [3:0] md_multu = 4'd2;
    localparam logic [3:0] md_div   = 4'd3;
    localparam logic [3:0] md_divu  = 4'd4;
    localparam logic [3:0] md_mthi  = 4'd5;
    localparam logic [3:0] md_mtlo  = 4'd6;
    localparam logic [3:0] md_mfhi  = 4'd7;
    localparam logic [3:0] md_mflo  = 4'd8;
    localparam logic [3:0] md_madd  = 4'd9;
    localparam logic [3:0] md_maddu = 4'd10;

    function automatic logic is_launch(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op >= md_mult && op <= md_divu) || op == md_madd || op == md_maddu;
`else
        return (op >= md_mult && op <= md_divu);
`endif
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == md_div) || (op == md_divu);
    endfunction

endpackage

// File: rtl/mdu_e_if.sv
// mdu_e_if: E-stage <-> multiply/divide unit signal bundle.
//   start, MDop[3:0], SrcA[31:0], SrcB[31:0], flush  : driven by the pipeline
//   busy, HI[31:0], LO[31:0], MDout[31:0]            : driven by the unit
// Modports: master (pipeline side), slave (mdu_e side).
interface mdu_e_if;
    logic        start;
    logic [3:0]  MDop;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        flush;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDout;

    modport master (output start, MDop, SrcA, SrcB, flush,
                    input  busy, HI, LO, MDout);
    modport slave  (input  start, MDop, SrcA, SrcB, flush,
                    output busy, HI, LO, MDout);
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational result generator for the multiply/divide unit.
//   MDop[3:0], SrcA[31:0], SrcB[31:0] : operation and operands
//   hi[31:0], lo[31:0]                : current HI/LO (madd accumulate, div-by-zero hold)
//   t_hi[31:0], t_lo[31:0]            : 64-bit result to be committed at completion
// Optional feature macro: MDU_MADD_EN (madd/maddu accumulate into HI/LO).
module mdu_arith
    import mdu_e_pkg::*;
(
    input  logic [3:0]  MDop,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] t_hi,
    output logic [31:0] t_lo
);

    logic [63:0] prod_s, prod_u;
    logic [31:0] mag_a, mag_b, q_mag, r_mag, q_u, r_u;

    always_comb begin
        // Low 64 bits of the product of sign-extended operands is the exact signed product.
        prod_s = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
        prod_u = {32'b0, SrcA} * {32'b0, SrcB};

        // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow corner:
        // magnitude 2^31 fits unsigned, and negating it wraps back to 0x80000000.
        mag_a = SrcA[31] ? (~SrcA + 32'd1) : SrcA;
        mag_b = SrcB[31] ? (~SrcB + 32'd1) : SrcB;
        q_mag = (mag_b != 32'd0) ? mag_a / mag_b : 32'd0;
        r_mag = (mag_b != 32'd0) ? mag_a % mag_b : 32'd0;
        q_u   = (SrcB  != 32'd0) ? SrcA / SrcB   : 32'd0;
        r_u   = (SrcB  != 32'd0) ? SrcA % SrcB   : 32'd0;

        // Default holds HI/LO, which is also the divide-by-zero result.
        {t_hi, t_lo} = {hi, lo};
        case (MDop)
            md_mult:  {t_hi, t_lo} = prod_s;
            md_multu: {t_hi, t_lo} = prod_u;
            md_div: begin
                if (SrcB != 32'd0) begin
                    t_lo = (SrcA[31] ^ SrcB[31]) ? (~q_mag + 32'd1) : q_mag;
                    t_hi = SrcA[31] ? (~r_mag + 32'd1) : r_mag;
                end
            end
            md_divu: begin
                if (SrcB != 32'd0) begin
                    t_lo = q_u;
                    t_hi = r_u;
                end
            end
`ifdef MDU_MADD_EN
            md_madd:  {t_hi, t_lo} = {hi, lo} + prod_s;
            md_maddu: {t_hi, t_lo} = {hi, lo} + prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_e.sv
// mdu_e: EX-stage multiply/divide sequencer owning the HI/LO pair.
//   clk        : rising-edge clock
//   reset      : synchronous, active-low
//   bus (slave): start/MDop/SrcA/SrcB/flush in; busy/HI/LO/MDout out
// Parameters: MULT_CYCLES (mult/multu/madd/maddu latency), DIV_CYCLES (div/divu latency),
// both >= 1 and <= 15.
// Optional feature macro: MDU_MADD_EN (madd = 9, maddu = 10 become launch ops).
module mdu_e
    import mdu_e_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    mdu_e_if.slave  bus
);

    typedef enum logic {st_idle, st_run} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] hi, lo, t_hi, t_lo;
    logic [31:0] a_hi, a_lo;

    mdu_arith u_arith (
        .MDop (bus.MDop),
        .SrcA (bus.SrcA),
        .SrcB (bus.SrcB),
        .hi   (hi),
        .lo   (lo),
        .t_hi (a_hi),
        .t_lo (a_lo)
    );

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= st_idle;
            cnt   <= 4'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            t_hi  <= 32'd0;
            t_lo  <= 32'd0;
        end else if (bus.flush) begin
            // Abort: pending tHI/tLO are simply never committed.
            state <= st_idle;
            cnt   <= 4'd0;
        end else begin
            case (state)
                st_idle: begin
                    if (bus.start && is_launch(bus.MDop)) begin
                        t_hi  <= a_hi;
                        t_lo  <= a_lo;
                        cnt   <= is_div(bus.MDop) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        state <= st_run;
                    end else if (bus.MDop == md_mthi) begin
                        hi <= bus.SrcA;
                    end else if (bus.MDop == md_mtlo) begin
                        lo <= bus.SrcA;
                    end
                end
                st_run: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        hi    <= t_hi;
                        lo    <= t_lo;
                        state <= st_idle;
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

    assign bus.busy = (state == st_run);
    assign bus.HI   = hi;
    assign bus.LO   = lo;

    always_comb begin
        bus.MDout = 32'd0;
        if (bus.MDop == md_mfhi)      bus.MDout = hi;
        else if (bus.MDop == md_mflo) bus.MDout = lo;
    end

endmodule

// File: tb/tb_mdu_e.sv
// tb_mdu_e: directed self-checking bench for mdu_e. Expected HI/LO results are
// pushed to a scoreboard queue at launch and popped when busy drops.
module tb_mdu_e;
    import mdu_e_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    logic [63:0] sb[$];

    mdu_e_if mif();

    mdu_e #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mif.start = 1'b0;
        mif.MDop  = md_none;
        mif.SrcA  = 32'd0;
        mif.SrcB  = 32'd0;
        mif.flush = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of the first non-busy cycle.
    task automatic launch(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [63:0] exp);
        int n;
        logic [63:0] want;
        sb.push_back(exp);
        mif.start = 1'b1; mif.MDop = op; mif.SrcA = a; mif.SrcB = b;
        @(negedge clk);
        idle_inputs();
        n = 0;
        while (mif.busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(lat));
        want = sb.pop_front();
        check({tag, "_hilo"}, {mif.HI, mif.LO}, want);
    endtask

    task automatic write_hilo(input logic [3:0] op, input logic [31:0] v);
        mif.MDop = op; mif.SrcA = v;
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Reset state
        check("rst_busy", 64'(mif.busy), 64'd0);
        check("rst_hilo", {mif.HI, mif.LO}, 64'd0);
        check("rst_mdout", 64'(mif.MDout), 64'd0);

        // Multiplies, back to back (second start in the completion cycle)
        launch("mult_neg2x3", md_mult, 32'hFFFF_FFFE, 32'd3, MULT_N, 64'hFFFF_FFFF_FFFF_FFFA);
        launch("multu_max", md_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_N, 64'hFFFF_FFFE_0000_0001);

        // Divides
        launch("div_m7_2", md_div, 32'hFFFF_FFF9, 32'd2, DIV_N, 64'hFFFF_FFFF_FFFF_FFFD);
        launch("divu_by0", md_divu, 32'd7, 32'd0, DIV_N, 64'hFFFF_FFFF_FFFF_FFFD);
        launch("divu_100_7", md_divu, 32'd100, 32'd7, DIV_N, 64'h0000_0002_0000_000E);
        launch("div_ovf", md_div, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 64'h0000_0000_8000_0000);

        // mthi / mfhi / mflo
        write_hilo(md_mthi, 32'h1234_5678);
        check("mthi_hilo", {mif.HI, mif.LO}, 64'h1234_5678_8000_0000);
        mif.MDop = md_mfhi; #1;
        check("mfhi_mdout", 64'(mif.MDout), 64'h1234_5678);
        mif.MDop = md_mflo; #1;
        check("mflo_mdout", 64'(mif.MDout), 64'h8000_0000);
        mif.MDop = md_mult; #1;
        check("other_mdout", 64'(mif.MDout), 64'd0);
        mif.MDop = md_none;
        write_hilo(md_mtlo, 32'h0BAD_F00D);
        check("mtlo_hilo", {mif.HI, mif.LO}, 64'h1234_5678_0BAD_F00D);

        // Flush at busy cycle 4 of a divide, with a competing start
        mif.start = 1'b1; mif.MDop = md_div; mif.SrcA = 32'd50; mif.SrcB = 32'd3;
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        check("flush_pre_busy", 64'(mif.busy), 64'd1);
        mif.flush = 1'b1; mif.start = 1'b1; mif.MDop = md_mult;
        mif.SrcA = 32'd9; mif.SrcB = 32'd9;
        @(negedge clk);
        idle_inputs();
        check("flush_busy", 64'(mif.busy), 64'd0);
        check("flush_hilo", {mif.HI, mif.LO}, 64'h1234_5678_0BAD_F00D);
        repeat (12) @(negedge clk);
        check("flush_after_busy", 64'(mif.busy), 64'd0);
        check("flush_after_hilo", {mif.HI, mif.LO}, 64'h1234_5678_0BAD_F00D);

        // mthi while busy is ignored
        mif.start = 1'b1; mif.MDop = md_multu; mif.SrcA = 32'd4; mif.SrcB = 32'd5;
        @(negedge clk);
        mif.start = 1'b0; mif.MDop = md_mthi; mif.SrcA = 32'hDEAD_BEEF;
        @(negedge clk);
        idle_inputs();
        repeat (MULT_N - 1) @(negedge clk);
        check("busy_mthi_hilo", {mif.HI, mif.LO}, 64'h0000_0000_0000_0014);

        // No-op codes
        mif.start = 1'b1; mif.MDop = md_none;
        @(negedge clk);
        check("none_busy", 64'(mif.busy), 64'd0);
`ifndef MDU_MADD_EN
        mif.MDop = md_madd; mif.SrcA = 32'd2; mif.SrcB = 32'd3;
        @(negedge clk);
        check("op9_busy", 64'(mif.busy), 64'd0);
        check("op9_hilo", {mif.HI, mif.LO}, 64'h0000_0000_0000_0014);
`endif
        idle_inputs();

        // Reset in busy cycle 2 of a multiply
        mif.start = 1'b1; mif.MDop = md_mult; mif.SrcA = 32'd7; mif.SrcB = 32'd7;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check("rst_mid_pre_busy", 64'(mif.busy), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rst_mid_busy", 64'(mif.busy), 64'd0);
        check("rst_mid_hilo", {mif.HI, mif.LO}, 64'd0);
        repeat (6) @(negedge clk);
        check("rst_mid_after_hilo", {mif.HI, mif.LO}, 64'd0);

`ifdef MDU_MADD_EN
        write_hilo(md_mtlo, 32'd5);
        launch("madd_2x3", md_madd, 32'd2, 32'd3, MULT_N, 64'h0000_0000_0000_000B);
        launch("maddu_carry", md_maddu, 32'hFFFF_FFFF, 32'h0000_0002, MULT_N,
               64'h0000_0002_0000_0009);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdu_e.md
# mdu_e

Multiply/divide sequencer for the EX stage of the five-stage MIPS pipeline. It owns the HI/LO register pair, launches mult/multu/div/divu operations, holds `busy` for a fixed multi-cycle latency, and writes HI/LO only when the operation completes. It also services mthi/mtlo/mfhi/mflo. The hazard unit stalls any MD-class instruction in D while `start | busy` is high.

## Interface
- MULT_CYCLES, 5: busy cycles for mult/multu (and madd/maddu when enabled); must be ≥1.
- DIV_CYCLES, 10: busy cycles for div/divu; must be ≥1.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle launch strobe from E-stage decode, valid for MDop codes 1–4 (and 9–10 when enabled).
- MDop  in  4  operation code; encodings live in the shared macros.
- SrcA  in  32  rs operand (forwarded).
- SrcB  in  32  rt operand (forwarded).
- flush  in  1  abort any in-flight operation.
- busy  out  1  an operation is in progress.
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.
- MDout  out  32  HI when MDop=mfhi, LO when MDop=mflo, else 0; combinational.

## Operation
- States: IDLE, RUN. Down-counter `cnt`, 4 bits wide, holds the remaining cycles.
- IDLE with start=1 and a legal launch op: compute the result into temp registers tHI/tLO, load `cnt` with MULT_CYCLES or DIV_CYCLES, go to RUN.
- start while in RUN is ignored. The hazard unit guarantees this never happens.
- RUN: decrement `cnt` each cycle. When cnt==1, copy tHI/tLO into HI/LO and return to IDLE.
- mult: {HI,LO} = $signed(SrcA)*$signed(SrcB), full 64 bits.
- multu: {HI,LO} is the unsigned 64-bit product.
- div/divu: LO is the quotient, truncated toward zero. HI is the remainder, with the sign of the dividend for div.
- Division by zero: the unit runs the full latency and leaves HI/LO unchanged.
- 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
- mthi/mtlo: write SrcA into HI/LO at the next edge, only when not busy. No RUN state is entered.
- mfhi/mflo: pure read, with no state change.
- MDop=0 (none) and unknown codes have no effect.
- flush=1: go to IDLE immediately (busy=0 next cycle) and discard tHI/tLO. HI/LO are unchanged. A start or mthi/mtlo in the same cycle is ignored.
- Reset (reset=0 at an edge): HI=0, LO=0, busy=0, state IDLE, cnt=0. Reset has priority over flush and start, including mid-operation.

## Timing
- start sampled at edge t.
- busy is high in cycles t+1 … t+N, where N is the latency.
- HI/LO carry the new value from cycle t+N+1. busy is low in the same cycle.
- A back-to-back start is accepted in cycle t+N+1.
- mthi/mtlo sampled at edge t: HI/LO are updated from cycle t+1.
- MDout and busy have no combinational path from start. MDout depends only on MDop and the registered HI/LO.
- All outputs after reset: 0.

## Configuration
- MDU_MADD_EN defined:
  - MDop 9 (madd) and 10 (maddu) are legal launch ops with MULT_CYCLES latency.
  - Result is {HI,LO} + product, computed from the HI/LO value at launch, mod 2^64.
  - Signed or unsigned product as the name implies.
- Undefined: codes 9/10 are treated as unknown (no effect, busy stays 0).

## Structure
- The shared macros include holds the `md_*` opcode constants: none=0, mult=1, multu=2, div=3, divu=4, mthi=5, mtlo=6, mfhi=7, mflo=8, madd=9, maddu=10.
- State encodings stay local.
- One sub-module is natural: `mdu_arith`. It is purely combinational and produces the 64-bit tHI/tLO from MDop/SrcA/SrcB/HI/LO.
- `mdu_e` keeps the FSM, counter, temp registers and HI/LO.

## Test plan
- Reset, then mult SrcA=0xFFFFFFFE (−2), SrcB=3 → busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu 0xFFFFFFFF × 0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div −7/2 → busy high for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu 7/0 → HI/LO keep their prior values and busy runs 10 cycles.
- mthi 0x12345678, then mflo/mfhi → HI updated one cycle later; MDout=0x12345678 with MDop=mfhi, and LO is unchanged.
- div started, flush asserted at busy cycle 4 → busy=0 next cycle, HI/LO unchanged. A second start in the same cycle as flush is ignored.
- Reset asserted mid-mult at busy cycle 2 → next cycle busy=0, HI=LO=0. With MDU_MADD_EN: HI=0, LO=5, then madd 2×3 → LO=11.
